// File: rtl/pbus_pkg.sv
// Shared types and constants for the LSPC PBUS address transmitter.
`default_nettype none

package pbus_pkg;

  localparam int PBUS_W   = 24;
  localparam int C_ADDR_W = 20;
  localparam int S_ADDR_W = 16;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Phase counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [3:0] cyc_reload(input int cyc);
    return 4'(cyc - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pbus_arbiter.sv
// Two-way round-robin arbiter; bit 0 = sprite (C-ROM), bit 1 = fix (S-ROM).
`default_nettype none

module pbus_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output logic       ptr_o
);

  // ptr_q = 1 when the last grant went to fix; reset value means "last was sprite".
  logic ptr_q;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = ptr_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (advance_i && (req_i != 2'b00)) begin
      ptr_q <= grant_o[1];
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/lspc_pbus_tx.sv
// PBUS address transmitter framing C/S fetches with PCK1B/PCK2B latch strobes.
// Optional build macro PBUS_IDLE_FLOAT_EN: release PBUS (OE low, bus 0) while idle.
`default_nettype none

module lspc_pbus_tx
  import pbus_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                CLK_24M,
  input  logic                nRESET,
  input  logic                SPR_REQ,
  input  logic [C_ADDR_W-1:0] SPR_ADDR,
  input  logic                FIX_REQ,
  input  logic [S_ADDR_W-1:0] FIX_ADDR,
  output logic                SPR_ACK,
  output logic                FIX_ACK,
  output logic [PBUS_W-1:0]   PBUS,
  output logic                PBUS_OE,
  output logic                PCK1B,
  output logic                PCK2B,
  output logic                BUSY
);

  localparam logic [3:0] SETUP_RLD = cyc_reload(SETUP_CYC);
  localparam logic [3:0] PULSE_RLD = cyc_reload(PULSE_CYC);
  localparam logic [3:0] HOLD_RLD  = cyc_reload(HOLD_CYC);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PBUS_W-1:0]   pbus_q, pbus_d;
  logic                oe_q, oe_d;
  logic                pck1b_q, pck1b_d;
  logic                pck2b_q, pck2b_d;
  logic                spr_ack_q, spr_ack_d;
  logic                fix_ack_q, fix_ack_d;
  logic                busy_q, busy_d;

  logic [1:0]          grant;
  logic                last_fix;
  logic                advance;
  logic                is_fix_d;

  // The arbiter pointer doubles as the type of the transaction in flight.
  pbus_arbiter u_arb (
    .clk_i     (CLK_24M),
    .rst_ni    (nRESET),
    .req_i     ({FIX_REQ, SPR_REQ}),
    .advance_i (advance),
    .grant_o   (grant),
    .ptr_o     (last_fix)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pbus_d   = pbus_q;
    advance  = 1'b0;
    is_fix_d = last_fix;

    case (state_q)
      ST_IDLE: begin
        if (SPR_REQ || FIX_REQ) begin
          state_d  = ST_SETUP;
          cnt_d    = SETUP_RLD;
          advance  = 1'b1;
          is_fix_d = grant[1];
          pbus_d   = grant[1] ? PBUS_W'(FIX_ADDR) : PBUS_W'(SPR_ADDR);
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_RLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_RLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

`ifdef PBUS_IDLE_FLOAT_EN
    if (state_d == ST_IDLE) begin
      pbus_d = '0;
    end
    oe_d = (state_d != ST_IDLE);
`else
    oe_d = 1'b1;
`endif

    // Outputs decoded from next state so every pin comes straight off a flop.
    pck1b_d   = !((state_d == ST_PULSE) && !is_fix_d);
    pck2b_d   = !((state_d == ST_PULSE) &&  is_fix_d);
    spr_ack_d = (state_d == ST_HOLD) && (cnt_d == 4'd0) && !is_fix_d;
    fix_ack_d = (state_d == ST_HOLD) && (cnt_d == 4'd0) &&  is_fix_d;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pbus_q    <= '0;
`ifdef PBUS_IDLE_FLOAT_EN
      oe_q      <= 1'b0;
`else
      oe_q      <= 1'b1;
`endif
      pck1b_q   <= 1'b1;
      pck2b_q   <= 1'b1;
      spr_ack_q <= 1'b0;
      fix_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pbus_q    <= pbus_d;
      oe_q      <= oe_d;
      pck1b_q   <= pck1b_d;
      pck2b_q   <= pck2b_d;
      spr_ack_q <= spr_ack_d;
      fix_ack_q <= fix_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign PBUS    = pbus_q;
  assign PBUS_OE = oe_q;
  assign PCK1B   = pck1b_q;
  assign PCK2B   = pck2b_q;
  assign SPR_ACK = spr_ack_q;
  assign FIX_ACK = fix_ack_q;
  assign BUSY    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_lspc_pbus_tx.sv
// Self-checking bench for lspc_pbus_tx: cycle-exact directed checks plus an ACK-driven scoreboard.
`default_nettype none

module tb_lspc_pbus_tx;

`ifdef PBUS_IDLE_FLOAT_EN
  localparam bit FLOAT = 1'b1;
`else
  localparam bit FLOAT = 1'b0;
`endif

  logic        clk;
  logic        nRESET;
  logic        spr_req, fix_req;
  logic [19:0] spr_addr;
  logic [15:0] fix_addr;
  logic        spr_ack, fix_ack, pbus_oe, pck1b, pck2b, busy;
  logic [23:0] pbus;

  logic        spr_req2;
  logic [19:0] spr_addr2;
  logic        fix_req2;
  logic [15:0] fix_addr2;
  logic        spr_ack2, fix_ack2, pbus_oe2, pck1b2, pck2b2, busy2;
  logic [23:0] pbus2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_fix;
    logic [23:0] addr;
  } txn_t;
  txn_t exp_q[$];
  txn_t sb_t;

  logic [19:0] c_latch;
  logic [15:0] s_latch;

  lspc_pbus_tx dut (
    .CLK_24M(clk), .nRESET(nRESET),
    .SPR_REQ(spr_req), .SPR_ADDR(spr_addr),
    .FIX_REQ(fix_req), .FIX_ADDR(fix_addr),
    .SPR_ACK(spr_ack), .FIX_ACK(fix_ack),
    .PBUS(pbus), .PBUS_OE(pbus_oe),
    .PCK1B(pck1b), .PCK2B(pck2b), .BUSY(busy)
  );

  lspc_pbus_tx #(.SETUP_CYC(1), .PULSE_CYC(3), .HOLD_CYC(2)) dut2 (
    .CLK_24M(clk), .nRESET(nRESET),
    .SPR_REQ(spr_req2), .SPR_ADDR(spr_addr2),
    .FIX_REQ(fix_req2), .FIX_ADDR(fix_addr2),
    .SPR_ACK(spr_ack2), .FIX_ACK(fix_ack2),
    .PBUS(pbus2), .PBUS_OE(pbus_oe2),
    .PCK1B(pck1b2), .PCK2B(pck2b2), .BUSY(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cartridge-side 273 latches capture on the strobe's rising edge.
  always @(posedge pck1b) c_latch <= pbus[19:0];
  always @(posedge pck2b) s_latch <= pbus[15:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (nRESET) begin
      check("strobe_excl", 32'(!pck1b && !pck2b), 32'd0);
      if (spr_ack || fix_ack) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_ack", 32'd1, 32'd0);
        end else begin
          sb_t = exp_q.pop_front();
          check("sb_type", 32'(fix_ack), 32'(sb_t.is_fix));
          check("sb_latch", sb_t.is_fix ? 32'(s_latch) : 32'(c_latch),
                sb_t.is_fix ? 32'(sb_t.addr[15:0]) : 32'(sb_t.addr[19:0]));
        end
      end
    end
  end

  // One default-timing transaction on dut; optional address change at cycle chg_k.
  task automatic run_single(input bit is_fix, input logic [23:0] pbus_exp,
                            input int chg_k, input logic [19:0] chg_addr);
    exp_q.push_back('{is_fix, pbus_exp});
    if (is_fix) begin
      fix_addr = pbus_exp[15:0];
      fix_req  = 1'b1;
    end else begin
      spr_addr = pbus_exp[19:0];
      spr_req  = 1'b1;
    end
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("s_pbus", 32'(pbus), (k == 6 && FLOAT) ? 32'd0 : 32'(pbus_exp));
      check("s_pck1b", 32'(pck1b), 32'(!(!is_fix && (k == 3 || k == 4))));
      check("s_pck2b", 32'(pck2b), 32'(!(is_fix && (k == 3 || k == 4))));
      check("s_spr_ack", 32'(spr_ack), 32'(!is_fix && k == 5));
      check("s_fix_ack", 32'(fix_ack), 32'(is_fix && k == 5));
      check("s_busy", 32'(busy), 32'(k <= 5));
      check("s_oe", 32'(pbus_oe), FLOAT ? 32'(k <= 5) : 32'd1);
      if (k == chg_k) spr_addr = chg_addr;
      if (k == 5) begin
        spr_req = 1'b0;
        fix_req = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRESET    = 1'b0;
    spr_req   = 1'b0; fix_req  = 1'b0;
    spr_addr  = '0;   fix_addr = '0;
    spr_req2  = 1'b0; fix_req2 = 1'b0;
    spr_addr2 = '0;   fix_addr2 = '0;
    repeat (3) @(negedge clk);

    check("rst_pbus", 32'(pbus), 32'd0);
    check("rst_pck1b", 32'(pck1b), 32'd1);
    check("rst_pck2b", 32'(pck2b), 32'd1);
    check("rst_acks", 32'({spr_ack, fix_ack}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'(pbus_oe), FLOAT ? 32'd0 : 32'd1);
    nRESET = 1'b1;
    @(negedge clk);

    run_single(1'b0, 24'h0ABCDE, 0, 20'h0);
    run_single(1'b1, 24'h001234, 0, 20'h0);
    check("t1_c_latch", 32'(c_latch), 32'h0ABCDE);
    check("t2_s_latch", 32'(s_latch), 32'h1234);

    // Fresh reset so the round-robin pointer is back to "last was SPR".
    nRESET = 1'b0;
    @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);
    spr_addr = 20'h11111;
    fix_addr = 16'h2222;
    exp_q.push_back('{1'b1, 24'h002222});
    exp_q.push_back('{1'b0, 24'h011111});
    exp_q.push_back('{1'b1, 24'h002222});
    spr_req = 1'b1;
    fix_req = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      check("rr_fix_ack", 32'(fix_ack), 32'(k == 5 || k == 17));
      check("rr_spr_ack", 32'(spr_ack), 32'(k == 11));
      check("rr_busy", 32'(busy), 32'((k % 6) != 0));
      check("rr_pck1b", 32'(pck1b), 32'(!(k == 9 || k == 10)));
      check("rr_pck2b", 32'(pck2b), 32'(!(k == 3 || k == 4 || k == 15 || k == 16)));
      if (k == 17) begin
        spr_req = 1'b0;
        fix_req = 1'b0;
      end
    end

    run_single(1'b0, 24'h05A5A5, 3, 20'h00001);
    check("t4_c_latch", 32'(c_latch), 32'h5A5A5);

    // Reset in the PULSE phase of a fix transaction.
    fix_addr = 16'hBEEF;
    fix_req  = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("ra_pck2b_low", 32'(pck2b), 32'd0);
    fix_req = 1'b0;
    #1 nRESET = 1'b0;
    #1;
    check("ra_pck2b_async", 32'(pck2b), 32'd1);
    check("ra_busy_async", 32'(busy), 32'd0);
    check("ra_pbus_async", 32'(pbus), 32'd0);
    @(negedge clk);
    nRESET = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("ra_no_ack", 32'(fix_ack), 32'd0);
      check("ra_busy", 32'(busy), 32'd0);
      check("ra_pbus", 32'(pbus), 32'd0);
    end

    // Non-default timing instance: SETUP=1, PULSE=3, HOLD=2.
    spr_addr2 = 20'h3C3C3;
    spr_req2  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("p2_ack", 32'(spr_ack2), 32'(k == 6));
      check("p2_fix_ack", 32'(fix_ack2), 32'd0);
      check("p2_pck1b", 32'(pck1b2), 32'(!(k >= 2 && k <= 4)));
      check("p2_pck2b", 32'(pck2b2), 32'd1);
      check("p2_busy", 32'(busy2), 32'(k <= 6));
      check("p2_pbus", 32'(pbus2), (FLOAT && k > 6) ? 32'd0 : 32'h03C3C3);
      check("p2_oe", 32'(pbus_oe2), FLOAT ? 32'(k <= 6) : 32'd1);
      if (k == 6) spr_req2 = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lspc_pbus_tx.md
# lspc_pbus_tx

PBUS address transmitter for the video side of the system board. It takes sprite-tile (C-ROM) and fix-tile (S-ROM) fetch requests from the LSPC fetch sequencer and drives them onto the multiplexed PBUS. It frames each request with an active-low PCK1B or PCK2B strobe so the cartridge's 273-style latches capture the address on the strobe's rising edge. It is the driving end of the PBUS/PCK latch protocol that the cartridge receives.

## Interface
Parameters:
- SETUP_CYC, 2: cycles PBUS is valid with strobe high before the strobe falls (1..15).
- PULSE_CYC, 2: cycles strobe is held low (1..15).
- HOLD_CYC, 1: cycles PBUS is held after the strobe rises (1..15).

Ports:
- CLK_24M, in, 1: sole clock; all state changes on its rising edge.
- nRESET, in, 1: asynchronous, active-low reset.
- SPR_REQ, in, 1: sprite fetch request; level, held until SPR_ACK.
- SPR_ADDR, in, 20: C-ROM tile address; stable while SPR_REQ is high.
- FIX_REQ, in, 1: fix fetch request; level, held until FIX_ACK.
- FIX_ADDR, in, 16: S-ROM fix address; stable while FIX_REQ is high.
- SPR_ACK, out, 1: one-cycle pulse when the sprite transaction completes.
- FIX_ACK, out, 1: one-cycle pulse when the fix transaction completes.
- PBUS, out, 24: address bus.
- PBUS_OE, out, 1: PBUS output enable.
- PCK1B, out, 1: C latch strobe, active low.
- PCK2B, out, 1: S latch strobe, active low.
- BUSY, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - Requests are sampled only in IDLE.
  - If either request is high, the arbiter grants one, latches the granted address and type, and moves to SETUP.
- Arbitration: round-robin.
  - On simultaneous requests, grant the type not granted last.
  - After reset, the first tie goes to FIX.
- PBUS contents:
  - Sprite transaction: PBUS = {4'b0, SPR_ADDR}.
  - Fix transaction: PBUS = {8'b0, FIX_ADDR}.
  - The latched copy is driven, so later input changes have no effect.
- SETUP (SETUP_CYC cycles): PBUS valid, both strobes high.
- PULSE (PULSE_CYC cycles): the strobe for the granted type (PCK1B sprite, PCK2B fix) is low. The other strobe stays high.
- HOLD (HOLD_CYC cycles):
  - Strobe high again; its rising edge at HOLD entry is the capture edge.
  - PBUS unchanged.
  - The matching ACK is high during the last HOLD cycle.
  - Then return to IDLE.
- Handshake:
  - The requester drops REQ no later than the cycle after ACK.
  - IDLE always lasts at least one cycle, so a REQ still high in the ACK cycle is not re-granted.
  - A REQ high in the first IDLE cycle is a new request.
- Phase counter: 4 bits, reloaded on each state entry, with no wrap beyond 15.
- Never both strobes low; never a strobe low outside PULSE.

## Timing
- Reset values: PBUS = 0, PCK1B = 1, PCK2B = 1, SPR_ACK = 0, FIX_ACK = 0, BUSY = 0, state IDLE, round-robin pointer = "last was SPR".
- PBUS_OE resets to 0 when the PBUS_IDLE_FLOAT_EN macro is defined, else 1.
- Latency with defaults: REQ sampled in IDLE at edge N.
  - SETUP occupies cycles N+1..N+2.
  - PULSE occupies cycles N+3..N+4.
  - HOLD/ACK occupies cycle N+5.
  - IDLE at N+6.
- General latency: ACK in cycle N+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- Throughput: one transaction per SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-transaction: outputs return to reset values immediately.
  - Reset during PULSE produces a strobe rising edge with a valid address. This is permitted.
  - No ACK is issued for the aborted transaction.

## Configuration
- PBUS_IDLE_FLOAT_EN defined:
  - PBUS_OE is high from SETUP entry through the end of HOLD and low in IDLE.
  - PBUS is driven 0 in IDLE, so the board can share PBUS with VRAM data.
- Undefined:
  - PBUS_OE is constant 1.
  - PBUS holds the last transmitted address through IDLE.

## Structure
- Package pbus_pkg holds:
  - The state enum.
  - Widths: PBUS_W = 24, C_ADDR_W = 20, S_ADDR_W = 16.
  - The default timing constants.
- Sub-module pbus_arbiter: two-way round-robin with inputs req[1:0] and advance, and outputs grant[1:0] and the pointer.
- The FSM, counter and output registers live in lspc_pbus_tx.

## Test plan
- Single sprite: SPR_ADDR = 20'hABCDE, SPR_REQ high.
  - PBUS = 24'h0ABCDE from N+1.
  - PCK1B low in N+3..N+4.
  - PCK2B never low.
  - SPR_ACK only at N+5.
  - A 273 model captures 20'hABCDE.
- Single fix: FIX_ADDR = 16'h1234.
  - PBUS = 24'h001234.
  - PCK2B low for 2 cycles.
  - FIX_ACK at N+5.
  - S latch model = 16'h1234.
- Simultaneous requests held 3 transactions: grants are FIX, SPR, FIX, with a 6-cycle period and one IDLE cycle between transactions.
- Address change mid-transaction: SPR_ADDR changes to 20'h00001 during PULSE. PBUS stays at the original value until IDLE.
- nRESET low during PULSE of a fix transaction:
  - PCK2B goes to 1 asynchronously.
  - No FIX_ACK.
  - After release, BUSY = 0 and PBUS = 0.
- SETUP_CYC = 1, PULSE_CYC = 3, HOLD_CYC = 2: ACK at N+6.
  - With PBUS_IDLE_FLOAT_EN defined, PBUS_OE is high only in N+1..N+6.
